inv_mix_columns_xor: RTL and testbench

- Decryption round back-end: AddRoundKey followed by InvMixColumns on one 128-bit AES state.
- Inverse counterpart of the encryption MixColumns/AddRoundKey stage. Sits after the InvShiftRows/InvSubBytes stage in the iterative decryption datapath.
- Walks the Rcon tag backwards (0x36 to 0x01 to 0x00) so the controller knows the round.
- Registered, valid/ready pipeline; the empty flag travels alongside each block.

---
 rtl/inv_mix_columns_xor.sv | 230 +++++++++++++++++++++++
 tb/tb_inv_mix_columns_xor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_xor.sv
// AES decryption round back-end: AddRoundKey then InvMixColumns, with Rcon tag walked backwards.
// Optional sticky illegal-tag detector enabled by defining INV_MIX_RCON_CHECK_EN.
module inv_mix_columns_xor #(
  parameter int unsigned REG_MID = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_in,
  input  logic         empty_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic [7:0]   rcon_out,
  output logic         empty,
  output logic         err
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] mul_0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] mul_0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] mul_0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Column word holds a0 in its top byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3);
    b1 = mul_09(a0) ^ mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3);
    b2 = mul_0d(a0) ^ mul_09(a1) ^ mul_0e(a2) ^ mul_0b(a3);
    b3 = mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2) ^ mul_0e(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] round_result(input logic [127:0] x, input logic [7:0] rcon);
    logic [127:0] r;
    if (rcon == 8'h00) begin
      r = x;
    end else begin
      for (int c = 0; c < 4; c++) begin
        r[127-32*c -: 32] = inv_mix_col(x[127-32*c -: 32]);
      end
    end
    return r;
  endfunction

  // Inverse xtime; 0x01 and 0x00 both collapse to the K0 tag.
  function automatic logic [7:0] rcon_prev(input logic [7:0] rc);
    logic [7:0] r;
    if (rc == 8'h00 || rc == 8'h01) begin
      r = 8'h00;
    end else if (!rc[0]) begin
      r = rc >> 1;
    end else begin
      r = ((rc ^ 8'h1b) >> 1) | 8'h80;
    end
    return r;
  endfunction

  logic         out_valid_q, out_valid_d;
  logic [127:0] state_out_q, state_out_d;
  logic [7:0]   rcon_out_q, rcon_out_d;
  logic         empty_q, empty_d;
  logic         out_load;

  // Source feeding the output register: mid stage or the raw inputs.
  logic         src_valid;
  logic [127:0] src_x;
  logic [7:0]   src_rcon;
  logic         src_empty;

  assign out_load = !out_valid_q || out_ready;

  if (REG_MID != 0) begin : g_mid
    logic         mid_valid_q, mid_valid_d;
    logic [127:0] mid_x_q, mid_x_d;
    logic [7:0]   mid_rcon_q, mid_rcon_d;
    logic         mid_empty_q, mid_empty_d;
    logic         mid_load;

    assign mid_load = !mid_valid_q || out_load;

    always_comb begin
      mid_valid_d = mid_valid_q;
      mid_x_d     = mid_x_q;
      mid_rcon_d  = mid_rcon_q;
      mid_empty_d = mid_empty_q;
      if (mid_load) begin
        mid_valid_d = in_valid;
        if (in_valid) begin
          mid_x_d     = state_in ^ key_in;
          mid_rcon_d  = rcon_in;
          mid_empty_d = empty_in;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mid_valid_q <= 1'b0;
        mid_x_q     <= '0;
        mid_rcon_q  <= '0;
        mid_empty_q <= 1'b1;
      end else begin
        mid_valid_q <= mid_valid_d;
        mid_x_q     <= mid_x_d;
        mid_rcon_q  <= mid_rcon_d;
        mid_empty_q <= mid_empty_d;
      end
    end

    assign in_ready  = mid_load;
    assign src_valid = mid_valid_q;
    assign src_x     = mid_x_q;
    assign src_rcon  = mid_rcon_q;
    assign src_empty = mid_empty_q;
  end else begin : g_direct
    assign in_ready  = out_load;
    assign src_valid = in_valid;
    assign src_x     = state_in ^ key_in;
    assign src_rcon  = rcon_in;
    assign src_empty = empty_in;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    state_out_d = state_out_q;
    rcon_out_d  = rcon_out_q;
    empty_d     = empty_q;
    if (out_load) begin
      out_valid_d = src_valid;
      if (src_valid) begin
        state_out_d = round_result(src_x, src_rcon);
        rcon_out_d  = rcon_prev(src_rcon);
        empty_d     = src_empty;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      state_out_q <= '0;
      rcon_out_q  <= '0;
      empty_q     <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      state_out_q <= state_out_d;
      rcon_out_q  <= rcon_out_d;
      empty_q     <= empty_d;
    end
  end

  assign out_valid = out_valid_q;
  assign state_out = state_out_q;
  assign rcon_out  = rcon_out_q;
  assign empty     = empty_q;

`ifdef INV_MIX_RCON_CHECK_EN
  function automatic logic rcon_legal(input logic [7:0] rc);
    logic ok;
    case (rc)
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (in_valid && in_ready && !rcon_legal(rcon_in)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inv_mix_columns_xor.sv
// Self-checking bench for inv_mix_columns_xor: vector table, stalled and random streams, reset.
module tb_inv_mix_columns_xor;

  localparam int LAT = 2;
`ifdef INV_MIX_RCON_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic [7:0]   rcon_in;
  logic         empty_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [7:0]   rcon_out;
  logic         empty;
  logic         err;

  always #5 clk = ~clk;

  inv_mix_columns_xor #(.REG_MID(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .key_in    (key_in),
    .rcon_in   (rcon_in),
    .empty_in  (empty_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .rcon_out  (rcon_out),
    .empty     (empty),
    .err       (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: polynomial multiply then reduce by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] st, input logic [127:0] key,
                                               input logic [7:0] rc);
    logic [7:0]   coef [4];
    logic [7:0]   a [16];
    logic [7:0]   acc;
    logic [127:0] x, r;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    x = st ^ key;
    if (rc == 8'h00) return x;
    for (int k = 0; k < 16; k++) a[k] = x[127-8*k -: 8];
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j - i + 4) % 4], a[4*c+j]);
        r[127-8*(4*c+i) -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Decryption walks the key schedule tags in this order.
  function automatic logic [7:0] model_rcon(input logic [7:0] rc);
    logic [7:0] seq [11];
    seq = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    for (int i = 0; i < 10; i++) if (seq[i] == rc) return seq[i+1];
    return 8'h00;
  endfunction

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic [7:0]   rc;
    logic         em;
    logic [127:0] exp_st;
    logic [7:0]   exp_rc;
  } vec_t;

  vec_t tbl [6];

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic [7:0]   rc;
    logic         em;
  } blk_t;

  blk_t blk [32];

  task automatic run_stream(input int n, input bit rand_stall, input string tag);
    int sent, recv, cyc;
    logic [7:0]   tags [11];
    logic         held;
    logic [127:0] held_st;
    logic [7:0]   held_rc;
    logic         held_em;
    tags = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    for (int i = 0; i < n; i++) begin
      blk[i].st  = {$urandom, $urandom, $urandom, $urandom};
      blk[i].key = {$urandom, $urandom, $urandom, $urandom};
      blk[i].rc  = tags[$urandom_range(0, 10)];
      blk[i].em  = 1'($urandom_range(0, 1));
    end
    sent = 0; recv = 0; cyc = 0; held = 1'b0;
    held_st = '0; held_rc = '0; held_em = 1'b0;
    while (recv < n && cyc < 300) begin
      @(posedge clk); #1;
      out_ready = rand_stall ? 1'($urandom_range(0, 1)) : !(cyc >= 3 && cyc <= 6);
      if (sent < n) begin
        in_valid = 1'b1;
        state_in = blk[sent].st;
        key_in   = blk[sent].key;
        rcon_in  = blk[sent].rc;
        empty_in = blk[sent].em;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (held) begin
        check({tag, "_hold_valid"}, out_valid, 1'b1);
        check({tag, "_hold_state"}, state_out, held_st);
        check({tag, "_hold_rcon"}, rcon_out, held_rc);
        check({tag, "_hold_empty"}, empty, held_em);
      end
      if (!out_ready && (sent - recv) == 2) check({tag, "_full_ready"}, in_ready, 1'b0);
      if (out_ready) check({tag, "_flow_ready"}, in_ready, 1'b1);
      if (out_valid && out_ready) begin
        if (recv >= sent) begin
          check({tag, "_spurious"}, 1'b1, 1'b0);
        end else begin
          check({tag, "_state"}, state_out, model_state(blk[recv].st, blk[recv].key, blk[recv].rc));
          check({tag, "_rcon"}, rcon_out, model_rcon(blk[recv].rc));
          check({tag, "_empty"}, empty, blk[recv].em);
        end
        recv++;
      end
      held = out_valid && !out_ready;
      held_st = state_out; held_rc = rcon_out; held_em = empty;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check({tag, "_count"}, 128'(recv), 128'(n));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int  lat;
    bit  got;
    bit  seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    state_in = '0; key_in = '0; rcon_in = '0; empty_in = 1'b0;

    tbl[0] = '{{4{32'h8e4da1bc}}, 128'h0, 8'h36, 1'b0, {4{32'hdb135345}}, 8'h1b};
    tbl[1] = '{{32'h9fdc589d, 96'h0}, 128'h0, 8'h1b, 1'b1, {32'hf20a225c, 96'h0}, 8'h80};
    tbl[2] = '{128'h00112233445566778899aabbccddeeff, 128'h0f0e0d0c0b0a09080706050403020100,
               8'h00, 1'b0, 128'h0f1f2f3f4f5f6f7f8f9fafbfcfdfefff, 8'h00};
    tbl[3] = '{128'h00112233445566778899aabbccddeeff, 128'h0f0e0d0c0b0a09080706050403020100,
               8'h01, 1'b1, 128'h0, 8'h00};
    tbl[3].exp_st = model_state(tbl[3].st, tbl[3].key, 8'h01);
    // Uniform columns are fixed points of InvMixColumns (0e^0b^0d^09 = 1).
    tbl[4] = '{{16{8'h5a}}, {16{8'ha5}}, 8'h02, 1'b0, {16{8'hff}}, 8'h01};
    tbl[5] = '{{16{8'h5a}}, 128'h0, 8'h03, 1'b0, {16{8'h5a}}, 8'h8c};

    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_state_out", state_out, 128'h0);
    check("rst_rcon_out", rcon_out, 8'h00);
    check("rst_empty", empty, 1'b1);
    check("rst_err", err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      state_in = tbl[i].st;
      key_in   = tbl[i].key;
      rcon_in  = tbl[i].rc;
      empty_in = tbl[i].em;
      @(negedge clk);
      check("vec_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      got = 1'b0; lat = 0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (out_valid) begin
          lat = c; got = 1'b1;
          break;
        end
      end
      check("vec_latency", 128'(lat), 128'(LAT));
      if (got) begin
        check("vec_state", state_out, tbl[i].exp_st);
        check("vec_rcon", rcon_out, tbl[i].exp_rc);
        check("vec_empty", empty, tbl[i].em);
        check("vec_err", err, (i == 5) ? EXP_ERR : 1'b0);
        @(negedge clk);
        check("vec_pulse", out_valid, 1'b0);
      end
    end

    run_stream(8, 1'b0, "stall");
    run_stream(24, 1'b1, "rand");
    check("err_sticky", err, EXP_ERR);

    // Two blocks in flight, then asynchronous reset between edges.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    state_in = {4{32'h01234567}}; key_in = '0; rcon_in = 8'h36; empty_in = 1'b0;
    @(posedge clk); #1;
    rcon_in = 8'h1b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_pre_valid", out_valid, 1'b1);
    check("rst_mid_pre_ready", in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_empty", empty, 1'b1);
    check("rst_mid_state", state_out, 128'h0);
    check("rst_mid_err", err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("rst_no_stale", seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
